// File: rtl/rbm_spike_vote_if.sv
// Handshake bundle between the RBM classifier stage and the spike vote block.
// rd_class/rd_count exist only when RBM_VOTE_READBACK_EN is defined.
interface rbm_spike_vote_if #(
    parameter int unsigned CNT_W   = 5,
    parameter int unsigned CLASS_W = 4
);
    logic               start;
    logic               spike_valid;
    logic [CLASS_W-1:0] spike_class;
    logic               spike;
    logic               iter_done;
    logic               busy;
    logic [CNT_W-1:0]   iter_count;
    logic               result_valid;
    logic [CLASS_W-1:0] result_class;
    logic [CNT_W-1:0]   result_count;
    logic               result_none;
    logic               class_err;
`ifdef RBM_VOTE_READBACK_EN
    logic [CLASS_W-1:0] rd_class;
    logic [CNT_W-1:0]   rd_count;
`endif

    modport master (
        output start, spike_valid, spike_class, spike, iter_done,
        input  busy, iter_count, result_valid, result_class, result_count, result_none,
               class_err
`ifdef RBM_VOTE_READBACK_EN
        , output rd_class
        , input  rd_count
`endif
    );

    modport slave (
        input  start, spike_valid, spike_class, spike, iter_done,
        output busy, iter_count, result_valid, result_class, result_count, result_none,
               class_err
`ifdef RBM_VOTE_READBACK_EN
        , input  rd_class
        , output rd_count
`endif
    );
endinterface

// File: rtl/rbm_spike_vote.sv
// Per-class spike vote counter with a one-class-per-cycle argmax scan.
// Define RBM_VOTE_READBACK_EN to add the combinational rd_class/rd_count readback.
module rbm_spike_vote #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned ITER_NUM    = 30,
    parameter int unsigned CNT_W       = 5,
    parameter int unsigned CLASS_W     = 4
) (
    input logic            clock,
    input logic            reset,
    rbm_spike_vote_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccum, StScan, StDone} state_t;

    localparam logic [CNT_W-1:0]   CntMax   = '1;
    localparam logic [CNT_W-1:0]   IterLast = CNT_W'(ITER_NUM);
    localparam logic [CLASS_W-1:0] IdxLast  = CLASS_W'(NUM_CLASSES - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0]   iter_count_q;
    logic [CLASS_W-1:0] scan_idx_q;
    logic [CLASS_W-1:0] best_idx_q;
    logic [CNT_W-1:0]   best_cnt_q;
    logic               busy_q;
    logic               result_valid_q;
    logic [CLASS_W-1:0] result_class_q;
    logic [CNT_W-1:0]   result_count_q;
    logic               result_none_q;
    logic               class_err_q;

    logic               in_range;
    logic [CNT_W-1:0]   scan_cnt;
    logic [CLASS_W-1:0] cand_idx;
    logic [CNT_W-1:0]   cand_cnt;
    logic [CNT_W-1:0]   iter_next;

    always_comb begin
        in_range = 32'(bus.spike_class) < NUM_CLASSES;
        scan_cnt = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (scan_idx_q == CLASS_W'(i)) scan_cnt = cnt_q[i];
        end
        // Index 0 seeds the running best; later classes win only on strictly greater count.
        if (scan_idx_q == '0 || scan_cnt > best_cnt_q) begin
            cand_idx = scan_idx_q;
            cand_cnt = scan_cnt;
        end else begin
            cand_idx = best_idx_q;
            cand_cnt = best_cnt_q;
        end
        iter_next = iter_count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
            iter_count_q   <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_count_q <= '0;
            result_none_q  <= 1'b0;
            class_err_q    <= 1'b0;
        end else if (bus.start) begin
            // Start from any state discards partial work and begins a fresh image.
            state_q        <= StAccum;
            for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
            iter_count_q   <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            busy_q         <= 1'b1;
            result_valid_q <= 1'b0;
            result_class_q <= '0;
            result_count_q <= '0;
            result_none_q  <= 1'b0;
            class_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (bus.spike_valid) begin
                        if (!in_range) class_err_q <= 1'b1;
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            if (bus.spike && bus.spike_class == CLASS_W'(i) && cnt_q[i] != CntMax)
                                cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    if (bus.iter_done) begin
                        iter_count_q <= iter_next;
                        if (iter_next == IterLast) begin
                            state_q    <= StScan;
                            scan_idx_q <= '0;
                        end
                    end
                end
                StScan: begin
                    best_idx_q <= cand_idx;
                    best_cnt_q <= cand_cnt;
                    if (scan_idx_q == IdxLast) begin
                        state_q        <= StDone;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_class_q <= cand_idx;
                        result_count_q <= cand_cnt;
                        // The winner holds the maximum, so a zero winner means every count is zero.
                        result_none_q  <= (cand_cnt == '0);
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                StIdle, StDone: ;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.iter_count   = iter_count_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_class = result_class_q;
    assign bus.result_count = result_count_q;
    assign bus.result_none  = result_none_q;
    assign bus.class_err    = class_err_q;

`ifdef RBM_VOTE_READBACK_EN
    always_comb begin
        bus.rd_count = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (bus.rd_class == CLASS_W'(i)) bus.rd_count = cnt_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_rbm_spike_vote.sv
// Scoreboard bench for rbm_spike_vote: stimulus queues expected votes, a monitor checks results.
module tb_rbm_spike_vote;
    localparam int NC = 10;
    localparam int IN = 30;
    localparam int CW = 5;
    localparam int KW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    rbm_spike_vote_if #(.CNT_W(CW), .CLASS_W(KW)) intf ();

    rbm_spike_vote #(
        .NUM_CLASSES(NC),
        .ITER_NUM   (IN),
        .CNT_W      (CW),
        .CLASS_W    (KW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (intf.slave)
    );

    typedef struct {
        int cls;
        int cnt;
        int none;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat   = 0;
    logic rv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic st, input logic sv, input logic [KW-1:0] cls,
                         input logic sp, input logic id);
        @(negedge clock);
        intf.start       = st;
        intf.spike_valid = sv;
        intf.spike_class = cls;
        intf.spike       = sp;
        intf.iter_done   = id;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // One iteration: every class presented once, iter_done on the last class.
    task automatic run_iter(input logic [NC-1:0] mask);
        for (int c = 0; c < NC; c++) drive(1'b0, 1'b1, KW'(c), mask[c], c == NC - 1);
    endtask

    task automatic push_exp(input int cls, input int cnt, input int none);
        exp_t e;
        e.cls  = cls;
        e.cnt  = cnt;
        e.none = none;
        exp_q.push_back(e);
    endtask

    task automatic wait_result();
        int  k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clock);
            seen = intf.result_valid;
            k++;
        end
        if (!seen) check("result_timeout", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        intf.start       = 1'b0;
        intf.spike_valid = 1'b0;
        intf.spike       = 1'b0;
        intf.iter_done   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: latency counts falling edges since the last sampled iter_done.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            if (intf.iter_done) lat = 0;
            @(negedge clock);
            lat++;
            if (intf.result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_class", 32'(intf.result_class), 32'(e.cls));
                    check("result_count", 32'(intf.result_count), 32'(e.cnt));
                    check("result_none", 32'(intf.result_none), 32'(e.none));
                    check("result_latency", 32'(lat), 32'(NC + 1));
                end
            end
            rv_prev = intf.result_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        intf.start       = 1'b0;
        intf.spike_valid = 1'b0;
        intf.spike_class = '0;
        intf.spike       = 1'b0;
        intf.iter_done   = 1'b0;
`ifdef RBM_VOTE_READBACK_EN
        intf.rd_class    = '0;
`endif
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(intf.busy), 32'd0);
        check("rst_iter_count", 32'(intf.iter_count), 32'd0);
        check("rst_result_valid", 32'(intf.result_valid), 32'd0);
        check("rst_result_class", 32'(intf.result_class), 32'd0);
        check("rst_result_count", 32'(intf.result_count), 32'd0);
        check("rst_result_none", 32'(intf.result_none), 32'd0);
        check("rst_class_err", 32'(intf.class_err), 32'd0);
        reset = 1'b0;

        // Reset in the middle of accumulation.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) run_iter('1);
        drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        idle(1);
        check("accum_busy", 32'(intf.busy), 32'd1);
        check("accum_iter_count", 32'(intf.iter_count), 32'd3);
        check("accum_class_err", 32'(intf.class_err), 32'd1);
        do_reset();
        check("midrst_busy", 32'(intf.busy), 32'd0);
        check("midrst_iter_count", 32'(intf.iter_count), 32'd0);
        check("midrst_class_err", 32'(intf.class_err), 32'd0);
        repeat (2) run_iter('1);
        drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
        idle(1);
        check("idle_busy", 32'(intf.busy), 32'd0);
        check("idle_iter_count", 32'(intf.iter_count), 32'd0);
        check("idle_class_err", 32'(intf.class_err), 32'd0);

        // Basic vote: class 7 every iteration, class 3 in the first 12.
        push_exp(7, 30, 0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int it = 0; it < IN; it++) begin
            run_iter((it < 12) ? 10'h088 : 10'h080);
            if (it == 14) begin
                idle(1);
                check("basic_mid_iter_count", 32'(intf.iter_count), 32'd15);
                check("basic_mid_busy", 32'(intf.busy), 32'd1);
            end
        end
        idle(1);
        wait_result();
        idle(1);
        check("done_busy", 32'(intf.busy), 32'd0);
        check("done_iter_count", 32'(intf.iter_count), 32'd30);
        run_iter('1);
        idle(1);
        check("done_hold_count", 32'(intf.result_count), 32'd30);
        check("done_hold_iter_count", 32'(intf.iter_count), 32'd30);
        check("done_hold_valid", 32'(intf.result_valid), 32'd1);

        // Tie between classes 2 and 5 resolves to the lower index.
        push_exp(2, 15, 0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int it = 0; it < IN; it++) run_iter((it < 15) ? 10'h024 : 10'h000);
        idle(1);
        wait_result();

        // All counts zero.
        push_exp(0, 0, 1);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int it = 0; it < IN; it++) run_iter('0);
        idle(1);
        wait_result();

        // Out-of-range class and a spike coincident with the final iter_done.
        push_exp(4, 1, 0);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
        idle(1);
        check("oor_class_err", 32'(intf.class_err), 32'd1);
        for (int it = 0; it < IN - 1; it++) run_iter('0);
        for (int c = 0; c < NC; c++) drive(1'b0, 1'b1, KW'(c), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 4'd4, 1'b1, 1'b1);
        idle(1);
        wait_result();
        check("oor_class_err_sticky", 32'(intf.class_err), 32'd1);

        // Abort during the scan: no result may appear.
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int it = 0; it < IN; it++) run_iter(10'h001);
        idle(3);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        check("scan_abort_busy", 32'(intf.busy), 32'd1);
        check("scan_abort_iter_count", 32'(intf.iter_count), 32'd0);
        check("scan_abort_valid", 32'(intf.result_valid), 32'd0);
        idle(20);

        // Abort at iteration 10, then a clean image with class 9 only.
        push_exp(9, 30, 0);
        for (int it = 0; it < 10; it++) run_iter(10'h20A);
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(1);
        check("abort_iter_count", 32'(intf.iter_count), 32'd0);
`ifdef RBM_VOTE_READBACK_EN
        intf.rd_class = 4'd9;
        #1;
        check("rd_after_abort", 32'(intf.rd_count), 32'd0);
`endif
        for (int it = 0; it < IN; it++) run_iter(10'h200);
        idle(1);
        wait_result();
`ifdef RBM_VOTE_READBACK_EN
        @(negedge clock);
        intf.rd_class = 4'd9;
        #1;
        check("rd_class9", 32'(intf.rd_count), 32'd30);
        intf.rd_class = 4'd1;
        #1;
        check("rd_class1", 32'(intf.rd_count), 32'd0);
        intf.rd_class = 4'd12;
        #1;
        check("rd_oor", 32'(intf.rd_count), 32'd0);
`endif

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
